// File: rtl/regbank_rd.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_rd
//  Purpose  : DEPTH x 32-bit flop register bank with a free-running write port
//             and a single-register, valid/ready handshaked read port.
//             Reads have one cycle of latency. A read and a write to the same
//             word in the same cycle forward the write data. A captured read
//             result is a snapshot that later writes cannot disturb.
//             Completed read handshakes are counted by a wrapping 16-bit
//             counter.
//  Ports    :
//    clk_i       in   1   clock, rising-edge active
//    rst_ni      in   1   synchronous active-low reset
//    wr_en_i     in   1   write strobe
//    wr_addr_i   in   AW  write word address
//    wr_data_i   in   32  write data
//    rd_req_i    in   1   read request
//    rd_addr_i   in   AW  read word address, used only when the request is granted
//    rd_gnt_o    out  1   combinational; read request accepted this cycle
//    rd_valid_o  out  1   rd_data_o holds a completed read
//    rd_data_o   out  32  registered read data
//    rd_ready_i  in   1   consumer takes rd_data_o this cycle
//    rd_count_o  out  16  number of completed read handshakes (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module regbank_rd #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_gnt_o,
  output logic          rd_valid_o,
  output logic [31:0]   rd_data_o,
  input  logic          rd_ready_i,
  output logic [15:0]   rd_count_o
);

  // --------------------------------------------------------------------------
  // Elaboration guard: the address must cover exactly DEPTH words so that no
  // address can select a non-existent word.
  // --------------------------------------------------------------------------
  generate
    if (DEPTH != (1 << AW)) begin : g_param_check
      $error("regbank_rd: DEPTH must equal 2**AW");
    end
  endgenerate

  localparam logic [31:0] C_ZERO_WORD = 32'h0000_0000;
  localparam logic [15:0] C_ZERO_CNT  = 16'h0000;
  localparam logic [15:0] C_ONE_CNT   = 16'h0001;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0][31:0] mem_q;
  logic [DEPTH-1:0][31:0] mem_d;
  logic                   valid_q, valid_d;
  logic [31:0]            data_q,  data_d;
  logic [15:0]            count_q, count_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic        w_out_free;   // output register can accept a new result
  logic        w_gnt;        // read accepted this cycle
  logic        w_handshake;  // consumer takes the current result this cycle
  logic        w_fwd;        // same-cycle write to the word being read
  logic [31:0] w_rd_word;    // word value the granted read will capture

  // The output register is free when empty, or when it is being drained in
  // this same cycle, which is what allows one read per cycle back-to-back.
  assign w_out_free  = ~valid_q | rd_ready_i;
  assign w_gnt       = rd_req_i & rst_ni & w_out_free;
  assign w_handshake = valid_q & rd_ready_i;

  // Write-first: a write landing on the addressed word this edge is what the
  // read returns, not the stale stored value.
  assign w_fwd     = wr_en_i & (wr_addr_i == rd_addr_i);
  assign w_rd_word = w_fwd ? wr_data_i : mem_q[rd_addr_i];

  // Storage next-state: only the addressed word takes the write data.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_addr_i] = wr_data_i;
    end
  end

  // Output register next-state. Data only changes on a grant, so a held
  // result is a snapshot that writes to its source word cannot alter, and a
  // drained result keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (w_gnt) begin
      valid_d = 1'b1;
      data_d  = w_rd_word;
    end else if (rd_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Handshake counter, wrapping naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if (w_handshake) begin
      count_d = count_q + C_ONE_CNT;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= C_ZERO_WORD;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // A pending, untaken result is discarded by reset without being counted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= C_ZERO_WORD;
      count_q <= C_ZERO_CNT;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_gnt_o   = w_gnt;
  assign rd_valid_o = valid_q;
  assign rd_data_o  = data_q;
  assign rd_count_o = count_q;

endmodule
`default_nettype wire
